// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM (dpram_param_be).
package dpram_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Helpers work on a wide container; callers zero-extend and truncate.
  localparam int MAX_W = 256;
  typedef logic [MAX_W-1:0] word_t;

  // Even parity: the stored bit makes the lane's total count of ones even.
  function automatic logic lane_parity(input word_t lane);
    return ^lane;
  endfunction

  // Lanes with be set take new_w, the others keep old_w.
  function automatic word_t merge_be(input word_t old_w, input word_t new_w,
                                     input word_t be, input int byte_w);
    word_t r;
    r = old_w;
    for (int b = 0; b < MAX_W; b++)
      if (be[b / byte_w]) r[b] = new_w[b];
    return r;
  endfunction

endpackage

// File: rtl/dpram_bank.sv
// Raw storage array with per-lane write enables and a registered, read-first read port.
module dpram_bank #(
  parameter int DATA_W = 8,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int NB = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dpram_param_be.sv
// Parametrised dual-port RAM: byte enables, RDW collision mode, post-reset clear sweep.
// Optional per-lane even parity with error flag when DPRAM_PARITY_EN is defined.
module dpram_param_be
  import dpram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = 11,
  parameter int DEPTH          = 2048,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     ren,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rvalid,
  output logic                     init_busy
`ifdef DPRAM_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              busy, w_in, r_in, wr_run, rd_acc, coll;
  logic              bank_we, bank_re;
  logic [IDX_W-1:0]  bank_wa;
  logic [NB-1:0]     bank_be;
  logic [DATA_W-1:0] bank_wd, bank_rd, rd_word;

  // Stage 1 sits alongside the bank's read register.
  logic              s1_vld_q, s1_vld_d, s1_zero_q, s1_zero_d, s1_coll_q, s1_coll_d;
  logic [DATA_W-1:0] s1_wd_q, s1_wd_d;
  logic [NB-1:0]     s1_be_q, s1_be_d;

  assign busy      = (state_q == CLEAR);
  assign init_busy = busy;
  assign w_in      = ({1'b0, waddr} < DEPTH_X);
  assign r_in      = ({1'b0, raddr} < DEPTH_X);
  assign wr_run    = !rst && !busy && wen && w_in;
  assign rd_acc    = !rst && !busy && ren;
  assign coll      = wen && (waddr == raddr);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (busy) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST) state_d = RUN;
    end
    s1_vld_d  = rd_acc;
    s1_zero_d = s1_zero_q;
    s1_coll_d = s1_coll_q;
    s1_wd_d   = s1_wd_q;
    s1_be_d   = s1_be_q;
    if (rd_acc) begin
      s1_zero_d = !r_in;
      s1_coll_d = coll;
      s1_wd_d   = data_in;
      s1_be_d   = be;
    end
  end

  // The clear sweep borrows the write port; reset suppresses every write.
  assign bank_we = !rst && (busy || wr_run);
  assign bank_wa = busy ? clr_cnt_q : waddr[IDX_W-1:0];
  assign bank_wd = busy ? '0 : data_in;
  assign bank_be = busy ? '1 : be;
  assign bank_re = rd_acc && r_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_zero_q <= 1'b1;
      s1_coll_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_zero_q <= s1_zero_d;
      s1_coll_q <= s1_coll_d;
    end
    s1_wd_q <= s1_wd_d;
    s1_be_q <= s1_be_d;
  end

  dpram_bank #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .ADDR_W(IDX_W)) u_data (
    .clk(clk), .we(bank_we), .be(bank_be), .waddr(bank_wa), .wdata(bank_wd),
    .re(bank_re), .raddr(raddr[IDX_W-1:0]), .rdata(bank_rd)
  );

  // Bank read is read-first; write-first overlays the lanes written on the read edge.
  always_comb begin
    rd_word = bank_rd;
    if (RDW_MODE == RDW_WRITE_FIRST && s1_coll_q)
      rd_word = DATA_W'(merge_be(word_t'(bank_rd), word_t'(s1_wd_q), word_t'(s1_be_q), BYTE_W));
    if (s1_zero_q) rd_word = '0;
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par_wd, par_rd, par_calc, par_new, par_exp, bank_pwd;
  logic          perr;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      par_wd[i]   = lane_parity(word_t'(data_in[i*BYTE_W +: BYTE_W]));
      par_new[i]  = lane_parity(word_t'(s1_wd_q[i*BYTE_W +: BYTE_W]));
      par_calc[i] = lane_parity(word_t'(rd_word[i*BYTE_W +: BYTE_W]));
    end
    par_exp = par_rd;
    if (RDW_MODE == RDW_WRITE_FIRST && s1_coll_q)
      par_exp = NB'(merge_be(word_t'(par_rd), word_t'(par_new), word_t'(s1_be_q), 1));
    perr = s1_vld_q && !s1_zero_q && (par_calc != par_exp);
  end

  assign bank_pwd = busy ? '0 : par_wd;

  dpram_bank #(.DATA_W(NB), .BYTE_W(1), .DEPTH(DEPTH), .ADDR_W(IDX_W)) u_par (
    .clk(clk), .we(bank_we), .be(bank_be), .waddr(bank_wa), .wdata(bank_pwd),
    .re(bank_re), .raddr(raddr[IDX_W-1:0]), .rdata(par_rd)
  );
`endif

  if (READ_LATENCY == 2) begin : g_lat2
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dout_q, dout_d;
`ifdef DPRAM_PARITY_EN
    logic              perr_q, perr_d;
    assign perr_d     = perr;
    assign parity_err = perr_q;
`endif
    assign vld_d = s1_vld_q;
    assign dout_d = s1_vld_q ? rd_word : dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        dout_q <= '0;
`ifdef DPRAM_PARITY_EN
        perr_q <= 1'b0;
`endif
      end else begin
        vld_q  <= vld_d;
        dout_q <= dout_d;
`ifdef DPRAM_PARITY_EN
        perr_q <= perr_d;
`endif
      end
    end

    assign data_out = dout_q;
    assign rvalid   = vld_q;
  end else begin : g_lat1
    assign data_out = rd_word;
    assign rvalid   = s1_vld_q;
`ifdef DPRAM_PARITY_EN
    assign parity_err = perr;
`endif
  end

endmodule

// File: tb/tb_dpram_param_be.sv
// Bench for dpram_param_be: two instances (latency 1 write-first, latency 2 read-first)
// driven in lockstep, checked per cycle against a transaction-level model.
module tb_dpram_param_be;

  localparam int DW = 32, AW = 4, DEPTH = 12;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wen, ren;
  logic [3:0]    be;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout_a, dout_b;
  logic          rv_a, rv_b, busy_a, busy_b;
`ifdef DPRAM_PARITY_EN
  logic          perr_a, perr_b;
`endif

  dpram_param_be #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW), .DEPTH(DEPTH),
                   .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .be(be), .waddr(waddr), .data_in(data_in),
    .ren(ren), .raddr(raddr), .data_out(dout_a), .rvalid(rv_a), .init_busy(busy_a)
`ifdef DPRAM_PARITY_EN
    , .parity_err(perr_a)
`endif
  );

  dpram_param_be #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW), .DEPTH(DEPTH),
                   .READ_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .be(be), .waddr(waddr), .data_in(data_in),
    .ren(ren), .raddr(raddr), .data_out(dout_b), .rvalid(rv_b), .init_busy(busy_b)
`ifdef DPRAM_PARITY_EN
    , .parity_err(perr_b)
`endif
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: word array, clear countdown, per-instance delivered result.
  logic [31:0] mm [DEPTH];
  int          busy_m = 0;
  logic [31:0] ed_a = '0, ed_b = '0, pd = '0;
  bit          ev_a = 0, ev_b = 0, pv = 0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic model_edge();
    logic [31:0] old_w;
    bit wr_ok, in_r;
    if (rst) begin
      busy_m = DEPTH;
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      ed_a = '0; ed_b = '0; ev_a = 0; ev_b = 0; pv = 0;
      return;
    end
    ev_a = 0;
    ev_b = pv;
    if (pv) ed_b = pd;
    pv = 0;
    if (busy_m > 0) begin
      busy_m--;
      return;
    end
    in_r  = (int'(raddr) < DEPTH);
    wr_ok = wen && (int'(waddr) < DEPTH);
    old_w = in_r ? mm[raddr] : '0;
    if (ren) begin
      ev_a = 1;
      ed_a = (in_r && wr_ok && waddr == raddr) ? lanes(old_w, data_in, be) : old_w;
      pv = 1;
      pd = old_w;
    end
    if (wr_ok) mm[waddr] = lanes(mm[waddr], data_in, be);
  endtask

  task automatic cycle(input bit r, input bit w, input logic [3:0] b, input int wa,
                       input logic [31:0] d, input bit re, input int ra);
    @(negedge clk);
    rst = r; wen = w; be = b; waddr = AW'(wa); data_in = d; ren = re; raddr = AW'(ra);
    @(posedge clk);
    model_edge();
    #1;
    chk("dout_a", dout_a, ed_a);
    chk("rvalid_a", 32'(rv_a), 32'(ev_a));
    chk("dout_b", dout_b, ed_b);
    chk("rvalid_b", 32'(rv_b), 32'(ev_b));
    chk("busy_a", 32'(busy_a), 32'(busy_m > 0));
    chk("busy_b", 32'(busy_b), 32'(busy_m > 0));
  endtask

  task automatic idle();
    cycle(0, 0, 4'h0, 0, '0, 0, 0);
  endtask

  typedef struct {
    bit          w;
    logic [3:0]  b;
    int          wa;
    logic [31:0] d;
    bit          r;
    int          ra;
    bit          ce;
    logic [31:0] xa, xb;
  } vec_t;

  vec_t tv [14];
  int   n;

  initial begin
    rst = 1; wen = 0; ren = 0; be = '0; waddr = '0; raddr = '0; data_in = '0;

    // Reset then count the clear sweep.
    cycle(1, 0, 4'h0, 0, '0, 0, 0);
    cycle(1, 0, 4'h0, 0, '0, 0, 0);
    chk("reset_busy", 32'(busy_a), 32'd1);
    chk("reset_dout_a", dout_a, 32'h0);
    n = 0;
    while (busy_a && n < 40) begin idle(); n++; end
    chk("clear_cycles", n, 32'd12);
    cycle(0, 0, 4'h0, 0, '0, 1, 5);
    chk("clear_read_rv", 32'(rv_a), 32'd1);
    chk("clear_read_data", dout_a, 32'h0);

    tv[0]  = '{1, 4'hF, 3,  32'hAABBCCDD, 0, 0,  0, 32'h0,        32'h0};
    tv[1]  = '{1, 4'h5, 3,  32'h11223344, 0, 0,  0, 32'h0,        32'h0};
    tv[2]  = '{0, 4'h0, 0,  32'h0,        1, 3,  1, 32'hAA22CC44, 32'hAA22CC44};
    tv[3]  = '{1, 4'hF, 7,  32'h0000005A, 0, 0,  0, 32'h0,        32'h0};
    tv[4]  = '{1, 4'h1, 7,  32'h000000A5, 1, 7,  1, 32'h000000A5, 32'h0000005A};
    tv[5]  = '{0, 4'h0, 0,  32'h0,        1, 7,  1, 32'h000000A5, 32'h000000A5};
    tv[6]  = '{1, 4'hF, 13, 32'hDEADBEEF, 0, 0,  0, 32'h0,        32'h0};
    tv[7]  = '{0, 4'h0, 0,  32'h0,        1, 13, 1, 32'h0,        32'h0};
    tv[8]  = '{1, 4'h0, 3,  32'hFFFFFFFF, 0, 0,  0, 32'h0,        32'h0};
    tv[9]  = '{0, 4'h0, 0,  32'h0,        1, 3,  1, 32'hAA22CC44, 32'hAA22CC44};
    tv[10] = '{1, 4'hF, 11, 32'h12345678, 1, 11, 1, 32'h12345678, 32'h0};
    tv[11] = '{0, 4'h0, 0,  32'h0,        1, 11, 1, 32'h12345678, 32'h12345678};
    tv[12] = '{1, 4'h8, 2,  32'hCAFEF00D, 1, 3,  1, 32'hAA22CC44, 32'hAA22CC44};
    tv[13] = '{0, 4'h0, 0,  32'h0,        1, 2,  1, 32'hCA000000, 32'hCA000000};
    foreach (tv[i]) begin
      cycle(0, tv[i].w, tv[i].b, tv[i].wa, tv[i].d, tv[i].r, tv[i].ra);
      idle();
      idle();
      if (tv[i].ce) begin
        chk($sformatf("vec%0d_a", i), dout_a, tv[i].xa);
        chk($sformatf("vec%0d_b", i), dout_b, tv[i].xb);
      end
    end

    // Back-to-back reads on the two-cycle instance.
    cycle(0, 1, 4'hF, 0, 32'h11111111, 0, 0);
    cycle(0, 1, 4'hF, 1, 32'h22222222, 0, 0);
    cycle(0, 1, 4'hF, 2, 32'h33333333, 0, 0);
    cycle(0, 0, 4'h0, 0, '0, 1, 0);
    chk("lat_e1_rv_b", 32'(rv_b), 32'd0);
    chk("lat_e1_a", dout_a, 32'h11111111);
    cycle(0, 0, 4'h0, 0, '0, 1, 1);
    chk("lat_e2_rv_b", 32'(rv_b), 32'd1);
    chk("lat_e2_b", dout_b, 32'h11111111);
    cycle(0, 0, 4'h0, 0, '0, 1, 2);
    chk("lat_e3_rv_b", 32'(rv_b), 32'd1);
    chk("lat_e3_b", dout_b, 32'h22222222);
    idle();
    chk("lat_e4_rv_b", 32'(rv_b), 32'd1);
    chk("lat_e4_b", dout_b, 32'h33333333);
    idle();
    chk("lat_e5_rv_b", 32'(rv_b), 32'd0);
    chk("lat_hold_b", dout_b, 32'h33333333);

    // Reset lands while a two-cycle read is in flight.
    cycle(0, 0, 4'h0, 0, '0, 1, 1);
    cycle(1, 1, 4'hF, 1, 32'h99999999, 1, 1);
    chk("rst_mid_rv_b", 32'(rv_b), 32'd0);
    chk("rst_mid_dout_b", dout_b, 32'h0);

    // Accesses during the sweep are dropped.
    for (int i = 0; i < 5; i++) cycle(0, 1, 4'hF, 2, 32'hFFFFFFFF, 1, 2);
    chk("clr_acc_rv_a", 32'(rv_a), 32'd0);
    n = 0;
    while (busy_a && n < 40) begin idle(); n++; end
    chk("clear_done", 32'(busy_a), 32'd0);
    cycle(0, 0, 4'h0, 0, '0, 1, 2);
    idle();
    chk("clr_addr2_a", dout_a, 32'h0);
    chk("clr_addr2_b", dout_b, 32'h0);
    cycle(0, 0, 4'h0, 0, '0, 1, 3);
    idle();
    chk("clr_addr3_b", dout_b, 32'h0);

`ifdef DPRAM_PARITY_EN
    cycle(0, 1, 4'hF, 3, 32'h01020304, 0, 0);
    dut_a.u_par.mem[3][0] = ~dut_a.u_par.mem[3][0];
    cycle(0, 0, 4'h0, 0, '0, 1, 3);
    chk("perr_flip_rv", 32'(rv_a), 32'd1);
    chk("perr_flip", 32'(perr_a), 32'd1);
    dut_a.u_par.mem[3][0] = ~dut_a.u_par.mem[3][0];
    cycle(0, 0, 4'h0, 0, '0, 1, 3);
    chk("perr_clean", 32'(perr_a), 32'd0);
    cycle(0, 0, 4'h0, 0, '0, 1, 13);
    chk("perr_oor", 32'(perr_a), 32'd0);
`endif

    // Random traffic, including out-of-range addresses and occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 32'($urandom),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
